l1_ring_request_arbiter: RTL and testbench

- Shares the core's single ring request injection slot between the instruction-cache and data-cache L1 miss queues.
- Picks one pending miss per cycle by round-robin, acks it back to its miss queue, and holds it in a one-entry output register until the ring controller reports a free slot.
- Sits between the two miss queues and the ring controller.
- Also keeps a saturating stall counter for performance monitoring.

---
 rtl/l1_ring_request_arbiter_pkg.sv | 18 +
 rtl/l1_ring_request_arbiter_arbiter.sv | 52 +++++
 rtl/l1_ring_request_arbiter.sv | 91 +++++++++
 tb/tb_l1_ring_request_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1_ring_request_arbiter_pkg.sv
// Shared types for the L1 ring request path: scalar width, line offset and ring source encoding.
package l1_ring_request_arbiter_pkg;

  typedef logic [31:0] scalar_t;

  localparam int CACHE_LINE_OFFSET_WIDTH = 6;

  typedef enum logic {
    RS_ICACHE = 1'b0,
    RS_DCACHE = 1'b1
  } ring_source_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/l1_ring_request_arbiter_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, combinational.
// Priority rotates past the last granted entry only when update_lru is pulsed.
module arbiter #(
  parameter int NUM_ENTRIES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] request,
  input  logic                   update_lru,
  output logic [NUM_ENTRIES-1:0] grant_oh
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [IDX_W-1:0]       last_idx;
  logic [IDX_W-1:0]       pick_any;
  logic [IDX_W-1:0]       pick_masked;
  logic                   have_masked;
  logic [NUM_ENTRIES-1:0] above_last;

  // Lowest requester strictly above the last winner, else lowest requester overall.
  always_comb begin
    pick_any    = '0;
    pick_masked = '0;
    have_masked = 1'b0;
    above_last  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      above_last[i] = (i > int'(last_idx));
      if (request[i]) begin
        pick_any = IDX_W'(i);
      end
      if (request[i] && above_last[i]) begin
        pick_masked = IDX_W'(i);
        have_masked = 1'b1;
      end
    end
    grant_oh = '0;
    if (|request) begin
      grant_oh = NUM_ENTRIES'(1) << (have_masked ? pick_masked : pick_any);
    end
  end

  // Reset points at the highest entry so entry 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_idx <= IDX_W'(NUM_ENTRIES - 1);
    end else if (update_lru && (|request)) begin
      last_idx <= have_masked ? pick_masked : pick_any;
    end
  end

endmodule

// File: rtl/l1_ring_request_arbiter.sv
// Shares the ring injection slot between I- and D-miss queues via a one-entry hold register.
// Latency: ready to ring_request_valid is 1 cycle; ack is same-cycle with the grant.
// Backpressure: no ack while the hold register is full and the ring slot is busy.
module l1_ring_request_arbiter
  import l1_ring_request_arbiter_pkg::*;
#(
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         icache_request_ready,
  input  scalar_t                      icache_request_address,
  output logic                         icache_request_ack,
  input  logic                         dcache_request_ready,
  input  scalar_t                      dcache_request_address,
  input  logic                         dcache_request_store,
  output logic                         dcache_request_ack,
  input  logic                         ring_slot_free,
  output logic                         ring_request_valid,
  output scalar_t                      ring_request_address,
  output logic                         ring_request_store,
  output logic                         ring_request_source,
  output logic [STALL_COUNT_WIDTH-1:0] stall_cycles
);

  hold_state_t  state;
  scalar_t      hold_address;
  logic         hold_store;
  ring_source_t hold_source;
  logic [1:0]   grant_oh;
  logic         can_accept;
  logic         grant_en;
  logic         dcache_win;

  // Gated by reset so acks stay low while the miss queues are also in reset.
  assign can_accept = reset && ((state == HOLD_EMPTY) || ring_slot_free);
  assign grant_en   = can_accept && (icache_request_ready || dcache_request_ready);
  assign dcache_win = grant_oh[1];

  arbiter #(
    .NUM_ENTRIES(2)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   ({dcache_request_ready, icache_request_ready}),
    .update_lru(grant_en),
    .grant_oh  (grant_oh)
  );

  assign icache_request_ack = can_accept && grant_oh[0];
  assign dcache_request_ack = can_accept && grant_oh[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= HOLD_EMPTY;
      hold_address <= '0;
      hold_store   <= 1'b0;
      hold_source  <= RS_ICACHE;
      stall_cycles <= '0;
    end else begin
      if (grant_en) begin
        state        <= HOLD_FULL;
        hold_address <= dcache_win ? dcache_request_address : icache_request_address;
        hold_store   <= dcache_win && dcache_request_store;
        hold_source  <= dcache_win ? RS_DCACHE : RS_ICACHE;
      end else if ((state == HOLD_FULL) && ring_slot_free) begin
        state <= HOLD_EMPTY;
      end
      if ((state == HOLD_FULL) && !ring_slot_free && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

  assign ring_request_valid   = (state == HOLD_FULL);
  assign ring_request_address = hold_address;
  assign ring_request_store   = hold_store;
  assign ring_request_source  = hold_source;

  a_one_ack : assert property (@(posedge clk) disable iff (!reset)
    !(icache_request_ack && dcache_request_ack));
  a_i_ack_ready : assert property (@(posedge clk) disable iff (!reset)
    icache_request_ack |-> icache_request_ready);
  a_d_ack_ready : assert property (@(posedge clk) disable iff (!reset)
    dcache_request_ack |-> dcache_request_ready);
  a_i_aligned : assert property (@(posedge clk) disable iff (!reset)
    icache_request_ack |-> (icache_request_address[CACHE_LINE_OFFSET_WIDTH-1:0] == '0));
  a_d_aligned : assert property (@(posedge clk) disable iff (!reset)
    dcache_request_ack |-> (dcache_request_address[CACHE_LINE_OFFSET_WIDTH-1:0] == '0));

endmodule

// File: tb/tb_l1_ring_request_arbiter.sv
// Directed plus random stimulus against a transaction-level model of the ring request arbiter.
module tb_l1_ring_request_arbiter;

  logic        clk;
  logic        reset;
  logic        icache_request_ready;
  logic [31:0] icache_request_address;
  logic        icache_request_ack;
  logic        dcache_request_ready;
  logic [31:0] dcache_request_address;
  logic        dcache_request_store;
  logic        dcache_request_ack;
  logic        ring_slot_free;
  logic        ring_request_valid;
  logic [31:0] ring_request_address;
  logic        ring_request_store;
  logic        ring_request_source;
  logic [15:0] stall_cycles;

  logic        w4_icache_ack;
  logic        w4_dcache_ack;
  logic        w4_valid;
  logic [31:0] w4_address;
  logic        w4_store;
  logic        w4_source;
  logic [3:0]  w4_stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: transaction-level view of the hold slot.
  bit          m_full;
  logic [31:0] m_addr;
  bit          m_store;
  bit          m_src;
  bit          m_last;
  int          m_stall;
  int          last_win;

  l1_ring_request_arbiter dut (
    .clk                   (clk),
    .reset                 (reset),
    .icache_request_ready  (icache_request_ready),
    .icache_request_address(icache_request_address),
    .icache_request_ack    (icache_request_ack),
    .dcache_request_ready  (dcache_request_ready),
    .dcache_request_address(dcache_request_address),
    .dcache_request_store  (dcache_request_store),
    .dcache_request_ack    (dcache_request_ack),
    .ring_slot_free        (ring_slot_free),
    .ring_request_valid    (ring_request_valid),
    .ring_request_address  (ring_request_address),
    .ring_request_store    (ring_request_store),
    .ring_request_source   (ring_request_source),
    .stall_cycles          (stall_cycles)
  );

  l1_ring_request_arbiter #(.STALL_COUNT_WIDTH(4)) dut_w4 (
    .clk                   (clk),
    .reset                 (reset),
    .icache_request_ready  (icache_request_ready),
    .icache_request_address(icache_request_address),
    .icache_request_ack    (w4_icache_ack),
    .dcache_request_ready  (dcache_request_ready),
    .dcache_request_address(dcache_request_address),
    .dcache_request_store  (dcache_request_store),
    .dcache_request_ack    (w4_dcache_ack),
    .ring_slot_free        (ring_slot_free),
    .ring_request_valid    (w4_valid),
    .ring_request_address  (w4_address),
    .ring_request_store    (w4_store),
    .ring_request_source   (w4_source),
    .stall_cycles          (w4_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_full  = 1'b0;
    m_addr  = '0;
    m_store = 1'b0;
    m_src   = 1'b0;
    m_last  = 1'b1;
    m_stall = 0;
  endtask

  // One clock cycle: drive, check same-cycle acks, clock, check held outputs.
  task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr,
                       input logic [31:0] da, input bit ds, input bit sf);
    int win;
    icache_request_ready   = ir;
    icache_request_address = ia;
    dcache_request_ready   = dr;
    dcache_request_address = da;
    dcache_request_store   = ds;
    ring_slot_free         = sf;
    #3;
    win = -1;
    if (!m_full || sf) begin
      if (ir && dr) win = m_last ? 0 : 1;
      else if (ir) win = 0;
      else if (dr) win = 1;
    end
    last_win = win;
    check("icache_ack", {31'b0, icache_request_ack}, {31'b0, win == 0});
    check("dcache_ack", {31'b0, dcache_request_ack}, {31'b0, win == 1});
    check("w4_icache_ack", {31'b0, w4_icache_ack}, {31'b0, win == 0});
    @(posedge clk);
    if (m_full && !sf) m_stall++;
    if (win == 0) begin
      m_full = 1'b1; m_addr = ia; m_store = 1'b0; m_src = 1'b0; m_last = 1'b0;
    end else if (win == 1) begin
      m_full = 1'b1; m_addr = da; m_store = ds; m_src = 1'b1; m_last = 1'b1;
    end else if (m_full && sf) begin
      m_full = 1'b0;
    end
    #1;
    check("valid", {31'b0, ring_request_valid}, {31'b0, m_full});
    check("w4_valid", {31'b0, w4_valid}, {31'b0, m_full});
    if (m_full) begin
      check("address", ring_request_address, m_addr);
      check("store", {31'b0, ring_request_store}, {31'b0, m_store});
      check("source", {31'b0, ring_request_source}, {31'b0, m_src});
    end
    check("stall16", {16'b0, stall_cycles}, 32'(sat(m_stall, 65535)));
    check("stall4", {28'b0, w4_stall_cycles}, 32'(sat(m_stall, 15)));
  endtask

  function automatic logic [31:0] rand_line();
    return $urandom() & 32'hFFFF_FFC0;
  endfunction

  initial begin
    logic [31:0] saved;
    int exp_src [4];
    exp_src = '{0, 1, 0, 1};

    // Reset asserted with requests pending: everything low.
    reset                  = 1'b0;
    icache_request_ready   = 1'b1;
    icache_request_address = 32'h0000_2000;
    dcache_request_ready   = 1'b1;
    dcache_request_address = 32'h0000_3000;
    dcache_request_store   = 1'b1;
    ring_slot_free         = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_icache_ack", {31'b0, icache_request_ack}, 32'd0);
    check("rst_dcache_ack", {31'b0, dcache_request_ack}, 32'd0);
    check("rst_valid", {31'b0, ring_request_valid}, 32'd0);
    check("rst_address", ring_request_address, 32'd0);
    check("rst_stall", {16'b0, stall_cycles}, 32'd0);
    reset = 1'b1;

    // Lone D-request with store.
    cycle(1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b1, 1'b0);
    check("d_first_ack", 32'(last_win), 32'd1);
    check("d_first_addr", ring_request_address, 32'h0000_1000);
    check("d_first_src", {31'b0, ring_request_source}, 32'd1);

    // Both ready, slot always free: strict alternation at full rate.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'h0001_0000 + 32'(k) * 32'h40, 1'b1, 32'h0002_0000 + 32'(k) * 32'h40,
            1'b0, 1'b1);
      check("rr_source_seq", {31'b0, ring_request_source}, 32'(exp_src[k]));
    end

    // Stalled while I-request waits.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 32'h0000_4440, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    check("stall_five", {16'b0, stall_cycles}, 32'd5);
    cycle(1'b1, 32'h0000_4440, 1'b0, 32'h0, 1'b0, 1'b1);
    check("unstall_ack", 32'(last_win), 32'd0);
    check("unstall_addr", ring_request_address, 32'h0000_4440);

    // Ready pulse while stalled, then squashed: hold register untouched.
    saved = ring_request_address;
    cycle(1'b1, 32'h0000_9900, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("squash_hold", ring_request_address, saved);

    // Long stall saturates the narrow counter.
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    check("stall4_saturated", {28'b0, w4_stall_cycles}, 32'd15);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(1)), rand_line(), 1'($urandom_range(1)), rand_line(),
            1'($urandom_range(1)), ($urandom_range(3) != 0));
    end

    // Reset mid-operation while full.
    cycle(1'b1, 32'h0000_7700, 1'b0, 32'h0, 1'b0, 1'b1);
    ring_slot_free       = 1'b0;
    icache_request_ready = 1'b1;
    dcache_request_ready = 1'b1;
    reset                = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, ring_request_valid}, 32'd0);
    check("mid_rst_address", ring_request_address, 32'd0);
    check("mid_rst_store", {31'b0, ring_request_store}, 32'd0);
    check("mid_rst_source", {31'b0, ring_request_source}, 32'd0);
    check("mid_rst_stall", {16'b0, stall_cycles}, 32'd0);
    check("mid_rst_stall4", {28'b0, w4_stall_cycles}, 32'd0);
    check("mid_rst_iack", {31'b0, icache_request_ack}, 32'd0);
    check("mid_rst_dack", {31'b0, dcache_request_ack}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_valid", {31'b0, ring_request_valid}, 32'd0);
    reset = 1'b1;
    model_reset();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("post_rst_idle", {31'b0, ring_request_valid}, 32'd0);
    cycle(1'b1, 32'h0000_0A40, 1'b1, 32'h0000_0B80, 1'b1, 1'b0);
    check("post_rst_tie_icache", 32'(last_win), 32'd0);
    check("post_rst_src", {31'b0, ring_request_source}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
